rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: the execute/ALU result path (ex) and the memory load-return path (ld).
- Uses valid/ready handshakes, fixed priority with ld first, and a starvation guard for ex.
- Accepted writes are registered and driven onto the reg file's wr_enable/wr_reg/wr_value one cycle later.
- Writes to address 15 pass through unchanged; the reg file resolves the accumulator indirection.

Parameters:
- REG_ADDR_WIDTH, 4, width of register addresses.
- REG_WIDTH, 8, width of register data.
- STARVE_LIMIT, 3, consecutive cycles ex may be refused before it gets priority; legal range 1..15.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- wb_hold  in  1  pipeline stall; blocks all grants while high.
- ex_valid  in  1  ex write request.
- ex_reg  in  REG_ADDR_WIDTH  ex destination register.
- ex_value  in  REG_WIDTH  ex write data.
- ex_ready  out  1  ex request accepted this cycle.
- ld_valid  in  1  ld write request.
- ld_reg  in  REG_ADDR_WIDTH  ld destination register.
- ld_value  in  REG_WIDTH  ld write data.
- ld_ready  out  1  ld request accepted this cycle.
- wr_enable  out  1  to reg file write enable.
- wr_reg  out  REG_ADDR_WIDTH  to reg file write address.
- wr_value  out  REG_WIDTH  to reg file write data.
- ex_starved  out  1  ex has priority this cycle (starvation guard active).

Behaviour:
- Reset (rst_n low at a rising edge):
  - wr_enable=0, wr_reg=0, wr_value=0, wait counter=0.
  - ex_starved=0; ex_ready=0 and ld_ready=0 in the cycle after reset.
  - Reset mid-operation drops any registered write; nothing reaches the reg file that cycle.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - A requester holds valid and its payload stable until accepted.
  - ready is combinational from the valid inputs, wb_hold and the registered arbiter state; it never depends on its own requester's payload.
  - At most one of ex_ready/ld_ready is high per cycle.
- Arbitration, each cycle with wb_hold=0:
  - Only one requester valid: it is granted.
  - Both valid and ex_starved=0: ld granted.
  - Both valid and ex_starved=1: ex granted.
  - Neither valid: no grant.
- wb_hold=1: no grant, both ready outputs low, wait counter holds its value.
- Output stage:
  - A grant in cycle N registers the payload; wr_enable=1 with that wr_reg/wr_value in cycle N+1, for exactly one cycle.
  - With no grant in cycle N, wr_enable=0 in N+1; wr_reg and wr_value hold their last values.
  - Sustained throughput is one write per cycle; latency is 1 cycle.
- Starvation counter (4 bits):
  - Increments on cycles where ex_valid=1, ex not granted, and wb_hold=0.
  - Clears on ex acceptance or on ex_valid=0.
  - Saturates at STARVE_LIMIT.
  - ex_starved = (counter == STARVE_LIMIT).
- Ordering:
  - Writes reach the reg file in grant order.
  - When both requesters target the same register, the later grant's data is what remains in the register.
- Addresses 14 and 15 are not special here; no hazard check is made. The reg file samples r14 at write time.

Decomposition:
- Package rf_wb_pkg holds:
  - Width constants REG_ADDR_WIDTH_C=4 and REG_WIDTH_C=8.
  - Enum grant_e {GNT_NONE, GNT_LD, GNT_EX}, 2 bits.
  - STARVE_CTR_WIDTH=4.
- One sub-module, wb_starve_ctr: the saturating wait counter plus ex_starved compare.
- Grant logic and the output register stay in rf_wb_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with both requesters valid -> wr_enable=0, wr_reg=0, wr_value=0, no ready asserted; first grant lands in the cycle after rst_n rises.
- Single ex: ex_valid=1, ex_reg=3, ex_value=0x5A at cycle N -> ex_ready=1 at N; wr_enable=1, wr_reg=3, wr_value=0x5A at N+1 only.
- Contention: ld (reg 2, 0x11) and ex (reg 2, 0x22) both valid continuously -> ld granted in cycles N..N+2; ex_starved=1 and ex granted at N+3; reg 2 ends at 0x22.
- Hold: wb_hold=1 for 3 cycles with ld_valid=1 -> no ready and wr_enable=0 throughout; ld granted on the first cycle after wb_hold drops; wait counter unchanged across the hold.
- Back-to-back: ld valid 4 consecutive cycles with values 0x01..0x04, ex idle -> 4 consecutive wr_enable cycles carrying 0x01..0x04 in order.
- Reset mid-stream: rst_n=0 in the cycle after an ld grant (reg 15, 0x77) -> wr_enable stays 0; the write never appears.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//   REG_ADDR_WIDTH_C : default register address width
//   REG_WIDTH_C      : default register data width
//   STARVE_CTR_WIDTH : width of the ex wait counter
//   grant_e          : which requester, if any, owns the write port this cycle
package rf_wb_pkg;

  localparam int unsigned REG_ADDR_WIDTH_C = 4;
  localparam int unsigned REG_WIDTH_C      = 8;
  localparam int unsigned STARVE_CTR_WIDTH = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_EX   = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of consecutive cycles the ex requester was refused.
//   clk, rst_n  : clock, synchronous active-low reset
//   hold        : writeback stall; the count is frozen while high
//   ex_valid    : ex is requesting
//   ex_granted  : ex accepted this cycle
//   starved     : count has reached STARVE_LIMIT, so ex wins contention
module wb_starve_ctr
  import rf_wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic ex_valid,
  input  logic ex_granted,
  output logic starved
);

  localparam logic [STARVE_CTR_WIDTH-1:0] LimitC = STARVE_CTR_WIDTH'(STARVE_LIMIT);

  logic [STARVE_CTR_WIDTH-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (hold) begin
      ctr_d = ctr_q;
    end else if (!ex_valid || ex_granted) begin
      ctr_d = '0;
    end else if (ctr_q != LimitC) begin
      ctr_d = ctr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign starved = (ctr_q == LimitC);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file's single write port between the ex (ALU result)
// and ld (load return) writeback paths. ld has fixed priority unless ex has been
// refused STARVE_LIMIT consecutive cycles. Accepted writes are registered and
// presented to the reg file one cycle later.
//   clk, rst_n                    : clock, synchronous active-low reset
//   wb_hold                       : stall, blocks every grant
//   ex_valid/ex_reg/ex_value      : ex request and payload; ex_ready = accepted
//   ld_valid/ld_reg/ld_value      : ld request and payload; ld_ready = accepted
//   wr_enable/wr_reg/wr_value     : reg file write port
//   ex_starved                    : ex currently outranks ld
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_C,
  parameter int unsigned REG_WIDTH      = REG_WIDTH_C,
  parameter int unsigned STARVE_LIMIT   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_hold,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg,
  input  logic [REG_WIDTH-1:0]      ex_value,
  output logic                      ex_ready,
  input  logic                      ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_reg,
  input  logic [REG_WIDTH-1:0]      ld_value,
  output logic                      ld_ready,
  output logic                      wr_enable,
  output logic [REG_ADDR_WIDTH-1:0] wr_reg,
  output logic [REG_WIDTH-1:0]      wr_value,
  output logic                      ex_starved
);

  grant_e grant;

  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [REG_WIDTH-1:0]      wr_value_q, wr_value_d;

  // Grant depends only on valids, hold and registered state, never on payloads.
  // Nothing is granted while reset is asserted, since the write would be dropped.
  always_comb begin
    grant = GNT_NONE;
    if (rst_n && !wb_hold) begin
      if (ld_valid && (!ex_valid || !ex_starved)) begin
        grant = GNT_LD;
      end else if (ex_valid) begin
        grant = GNT_EX;
      end
    end
  end

  assign ex_ready = (grant == GNT_EX);
  assign ld_ready = (grant == GNT_LD);

  wb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (wb_hold),
    .ex_valid  (ex_valid),
    .ex_granted(ex_ready),
    .starved   (ex_starved)
  );

  // Address and data hold their last values when no write is granted.
  always_comb begin
    wr_en_d    = 1'b0;
    wr_reg_d   = wr_reg_q;
    wr_value_d = wr_value_q;
    unique case (grant)
      GNT_LD: begin
        wr_en_d    = 1'b1;
        wr_reg_d   = ld_reg;
        wr_value_d = ld_value;
      end
      GNT_EX: begin
        wr_en_d    = 1'b1;
        wr_reg_d   = ex_reg;
        wr_value_d = ex_value;
      end
      default: begin
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      wr_value_q <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_reg_q   <= wr_reg_d;
      wr_value_q <= wr_value_d;
    end
  end

  // A write already registered is suppressed if reset arrives in its output
  // cycle, so a reset never lets a stale write reach the reg file.
  assign wr_enable = wr_en_q & rst_n;
  assign wr_reg    = wr_reg_q;
  assign wr_value  = wr_value_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int LIMIT = 3;

  logic       clk = 1'b0;
  logic       rst_n, wb_hold;
  logic       ex_valid, ld_valid;
  logic [3:0] ex_reg, ld_reg;
  logic [7:0] ex_value, ld_value;
  logic       ex_ready, ld_ready, wr_enable, ex_starved;
  logic [3:0] wr_reg;
  logic [7:0] wr_value;

  rf_wb_arbiter #(
    .REG_ADDR_WIDTH(4),
    .REG_WIDTH     (8),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_hold   (wb_hold),
    .ex_valid  (ex_valid),
    .ex_reg    (ex_reg),
    .ex_value  (ex_value),
    .ex_ready  (ex_ready),
    .ld_valid  (ld_valid),
    .ld_reg    (ld_reg),
    .ld_value  (ld_value),
    .ld_ready  (ld_ready),
    .wr_enable (wr_enable),
    .wr_reg    (wr_reg),
    .wr_value  (wr_value),
    .ex_starved(ex_starved)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [3:0] r;
    logic [7:0] v;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  int         ex_wait = 0;    // consecutive stall-free cycles ex was refused
  logic [7:0] rf_obs[16];     // reg file contents as seen on the write port
  logic [3:0] held_reg = '0;
  logic [7:0] held_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the write port against the scoreboard every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      wr_t e;
      bit  due;
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("write_late", 32'(exp_q[0].due), 32'(cyc));
        void'(exp_q.pop_front());
      end
      if (due) begin
        e = exp_q.pop_front();
        chk("wr_enable", {31'd0, wr_enable}, {31'd0, rst_n});
        chk("wr_reg", {28'd0, wr_reg}, {28'd0, e.r});
        chk("wr_value", {24'd0, wr_value}, {24'd0, e.v});
        held_reg = e.r;
        held_val = e.v;
      end else begin
        chk("wr_enable_idle", {31'd0, wr_enable}, 32'd0);
        chk("wr_reg_hold", {28'd0, wr_reg}, {28'd0, held_reg});
        chk("wr_value_hold", {24'd0, wr_value}, {24'd0, held_val});
      end
      if (wr_enable === 1'b1) rf_obs[wr_reg] = wr_value;
      if (!rst_n) begin
        held_reg = '0;
        held_val = '0;
      end
    end
  end

  // One cycle of stimulus, with the reference model's prediction of the grant.
  // gnt: 0 none, 1 ld, 2 ex.
  task automatic step(input logic rst_v, input logic hold_v,
                      input logic exv, input logic [3:0] exr, input logic [7:0] exd,
                      input logic ldv, input logic [3:0] ldr, input logic [7:0] ldd,
                      output int gnt);
    bit starved;
    @(posedge clk);
    #1;
    rst_n = rst_v; wb_hold = hold_v;
    ex_valid = exv; ex_reg = exr; ex_value = exd;
    ld_valid = ldv; ld_reg = ldr; ld_value = ldd;
    @(negedge clk);
    starved = (ex_wait >= LIMIT);
    if (!rst_v || hold_v)        gnt = 0;
    else if (exv && ldv)         gnt = starved ? 2 : 1;
    else if (exv)                gnt = 2;
    else if (ldv)                gnt = 1;
    else                         gnt = 0;
    chk("ex_starved", {31'd0, ex_starved}, {31'd0, starved});
    chk("ex_ready", {31'd0, ex_ready}, (gnt == 2) ? 32'd1 : 32'd0);
    chk("ld_ready", {31'd0, ld_ready}, (gnt == 1) ? 32'd1 : 32'd0);
    if (gnt == 1) exp_q.push_back('{due: cyc + 1, r: ldr, v: ldd});
    if (gnt == 2) exp_q.push_back('{due: cyc + 1, r: exr, v: exd});
    if (!rst_v)                  ex_wait = 0;
    else if (hold_v)             ex_wait = ex_wait;
    else if (!exv || gnt == 2)   ex_wait = 0;
    else                         ex_wait = ex_wait + 1;
  endtask

  initial begin
    int g;
    logic       exv, ldv, hv, rv;
    logic [3:0] exr, ldr;
    logic [7:0] exd, ldd;

    for (int i = 0; i < 16; i++) rf_obs[i] = '0;
    rst_n = 1'b0; wb_hold = 1'b0;
    ex_valid = 1'b1; ex_reg = 4'd1; ex_value = 8'hAA;
    ld_valid = 1'b1; ld_reg = 4'd2; ld_value = 8'hBB;
    @(posedge clk);
    chk_en = 1'b1;

    // Reset held with both requesters valid, then first grant right after.
    step(0, 0, 1, 4'd1, 8'hAA, 1, 4'd2, 8'hBB, g);
    step(0, 0, 1, 4'd1, 8'hAA, 1, 4'd2, 8'hBB, g);
    step(1, 0, 0, 4'd0, 8'h00, 1, 4'd2, 8'hBB, g);
    chk("first_grant_ld", 32'(g), 32'd1);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);

    // Single ex write.
    step(1, 0, 1, 4'd3, 8'h5A, 0, 4'd0, 8'h00, g);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);

    // Contention on reg 2: ld three times, then ex by starvation.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 4'd2, 8'h22, 1, 4'd2, 8'h11, g);
    step(1, 0, 1, 4'd2, 8'h22, 1, 4'd2, 8'h11, g);
    chk("starved_ex_grant", 32'(g), 32'd2);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);
    chk("reg2_final", {24'd0, rf_obs[2]}, 32'h22);

    // Hold with both valid: wait count must freeze at 2 across the stall.
    step(1, 0, 1, 4'd4, 8'h44, 1, 4'd5, 8'h55, g);
    step(1, 0, 1, 4'd4, 8'h44, 1, 4'd5, 8'h56, g);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 4'd4, 8'h44, 1, 4'd5, 8'h57, g);
    step(1, 0, 1, 4'd4, 8'h44, 1, 4'd5, 8'h57, g);
    chk("ld_after_hold", 32'(g), 32'd1);
    step(1, 0, 1, 4'd4, 8'h44, 1, 4'd5, 8'h58, g);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);

    // Back-to-back ld writes.
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 4'd0, 8'h00, 1, 4'd6, 8'(i), g);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);

    // Reset in the output cycle of an ld grant drops the write.
    step(1, 0, 0, 4'd0, 8'h00, 1, 4'd15, 8'h77, g);
    step(0, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);
    chk("reg15_dropped", {24'd0, rf_obs[15]}, 32'h0);

    // Randomized traffic; each requester keeps its payload until accepted.
    exv = 0; ldv = 0; exr = '0; ldr = '0; exd = '0; ldd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!exv && ($urandom_range(99) < 60)) begin
        exv = 1; exr = 4'($urandom); exd = 8'($urandom);
      end
      if (!ldv && ($urandom_range(99) < 60)) begin
        ldv = 1; ldr = 4'($urandom); ldd = 8'($urandom);
      end
      hv = ($urandom_range(99) < 15);
      rv = ($urandom_range(99) >= 2);
      step(rv, hv, exv, exr, exd, ldv, ldr, ldd, g);
      if (g == 2) exv = 0;
      if (g == 1) ldv = 0;
    end

    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);
    step(1, 0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, g);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
